// File: rtl/readout_stream_arbiter.sv
// Round-robin merge of per-module readout FIFOs into one word stream, with a
// per-grant burst limit, hold support for contiguous groups and a registered output.
module readout_stream_arbiter #(
    parameter int WIDTH     = 4,
    parameter int DATA_BITS = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                                       BUS_CLK,
    input  logic                                       BUS_RSTB,
    input  logic [WIDTH-1:0]                           EN_MASK,
    input  logic [WIDTH-1:0]                           WRITE_REQ,
    input  logic [WIDTH-1:0]                           HOLD_REQ,
    input  logic [WIDTH*DATA_BITS-1:0]                 DATA_IN,
    output logic [WIDTH-1:0]                           READ_GRANT,
    input  logic                                       READY_OUT,
    output logic                                       WRITE_OUT,
    output logic [DATA_BITS-1:0]                       DATA_OUT,
    output logic [(WIDTH > 1 ? $clog2(WIDTH) : 1)-1:0] GRANT_ID,
    output logic                                       BUSY
);

    localparam int ID_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t               state_reg, state_next;
    logic [ID_W-1:0]      grant_id_reg, grant_id_next;
    logic [ID_W-1:0]      last_ptr_reg, last_ptr_next;
    logic [CNT_W-1:0]     burst_cnt_reg, burst_cnt_next;
    logic                 write_out_reg, write_out_next;
    logic [DATA_BITS-1:0] data_out_reg, data_out_next;

    logic [WIDTH-1:0]     eligible;
    logic [DATA_BITS-1:0] src_word [WIDTH];
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_valid;
    int                   pick_cand;
    logic                 can_load;
    logic                 cnt_ok;
    logic                 pop;
    logic                 exit_grant;

    assign eligible = WRITE_REQ & EN_MASK;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_src
            assign src_word[gi]   = DATA_IN[gi*DATA_BITS +: DATA_BITS];
            assign READ_GRANT[gi] = pop && (grant_id_reg == ID_W'(gi));
        end
    endgenerate

    // Scan from farthest to nearest so the first eligible index after the
    // last pointer is the one that survives.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_cand  = 0;
        for (int k = WIDTH; k >= 1; k--) begin
            pick_cand = int'(last_ptr_reg) + k;
            if (pick_cand >= WIDTH) begin
                pick_cand = pick_cand - WIDTH;
            end
            if (eligible[ID_W'(pick_cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = ID_W'(pick_cand);
            end
        end
    end

    assign can_load = !write_out_reg || READY_OUT;
    assign cnt_ok   = (burst_cnt_reg < BURST_MAX) || HOLD_REQ[grant_id_reg];
    assign pop      = (state_reg == ST_GRANT) && eligible[grant_id_reg] && cnt_ok && can_load;

    always_comb begin
        state_next     = state_reg;
        grant_id_next  = grant_id_reg;
        last_ptr_next  = last_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        write_out_next = write_out_reg;
        data_out_next  = data_out_reg;
        exit_grant     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next     = ST_GRANT;
                    grant_id_next  = pick_idx;
                    last_ptr_next  = pick_idx;
                    burst_cnt_next = '0;
                end
            end
            ST_GRANT: begin
                if (pop && (burst_cnt_reg != BURST_MAX)) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
                // A held source keeps the grant through empty gaps and past the limit.
                exit_grant = !EN_MASK[grant_id_reg] ||
                             (!HOLD_REQ[grant_id_reg] &&
                              ((burst_cnt_next == BURST_MAX) || !WRITE_REQ[grant_id_reg]));
                if (exit_grant) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (pop) begin
            write_out_next = 1'b1;
            data_out_next  = src_word[grant_id_reg];
        end else if (write_out_reg && READY_OUT) begin
            write_out_next = 1'b0;
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RSTB) begin
        if (!BUS_RSTB) begin
            state_reg     <= ST_IDLE;
            grant_id_reg  <= '0;
            last_ptr_reg  <= ID_W'(WIDTH - 1);
            burst_cnt_reg <= '0;
            write_out_reg <= 1'b0;
            data_out_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            grant_id_reg  <= grant_id_next;
            last_ptr_reg  <= last_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
            write_out_reg <= write_out_next;
            data_out_reg  <= data_out_next;
        end
    end

    assign WRITE_OUT = write_out_reg;
    assign DATA_OUT  = data_out_reg;
    assign GRANT_ID  = grant_id_reg;
    assign BUSY      = (state_reg == ST_GRANT);

endmodule

// File: tb/tb_readout_stream_arbiter.sv
// Randomized bench for readout_stream_arbiter: source FIFOs modelled as arrays,
// a rule-level reference model of grants/output stage, and an end-to-end word scoreboard.
module tb_readout_stream_arbiter;

    localparam int WIDTH     = 4;
    localparam int DATA_BITS = 32;
    localparam int MAX_BURST = 4;
    localparam int DEPTH     = 2048;

    logic                       BUS_CLK = 1'b0;
    logic                       BUS_RSTB;
    logic [WIDTH-1:0]           EN_MASK;
    logic [WIDTH-1:0]           WRITE_REQ;
    logic [WIDTH-1:0]           HOLD_REQ;
    logic [WIDTH*DATA_BITS-1:0] DATA_IN;
    logic [WIDTH-1:0]           READ_GRANT;
    logic                       READY_OUT;
    logic                       WRITE_OUT;
    logic [DATA_BITS-1:0]       DATA_OUT;
    logic [1:0]                 GRANT_ID;
    logic                       BUSY;

    logic [31:0] din_word [WIDTH];
    assign DATA_IN = {din_word[3], din_word[2], din_word[1], din_word[0]};

    readout_stream_arbiter #(
        .WIDTH(WIDTH),
        .DATA_BITS(DATA_BITS),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .BUS_CLK(BUS_CLK),
        .BUS_RSTB(BUS_RSTB),
        .EN_MASK(EN_MASK),
        .WRITE_REQ(WRITE_REQ),
        .HOLD_REQ(HOLD_REQ),
        .DATA_IN(DATA_IN),
        .READ_GRANT(READ_GRANT),
        .READY_OUT(READY_OUT),
        .WRITE_OUT(WRITE_OUT),
        .DATA_OUT(DATA_OUT),
        .GRANT_ID(GRANT_ID),
        .BUSY(BUSY)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Source FIFOs (first-word-fall-through), one array per source.
    logic [31:0] fifo_mem [WIDTH][DEPTH];
    int          fifo_head [WIDTH];
    int          fifo_tail [WIDTH];
    logic [31:0] outq [$];

    // Reference model state: who owns the stream, words taken this grant, output register.
    bit          m_busy;
    logic [1:0]  m_owner;
    logic [1:0]  m_last;
    logic [1:0]  m_shown;
    int          m_taken;
    bit          m_full;
    logic [31:0] m_word;

    int p_arrive, p_ready, p_hold, p_mask;
    bit fair_mode;

    task automatic push_word(input int i);
        logic [1:0] s;
        s = i[1:0];
        if (fifo_tail[s] < DEPTH) begin
            fifo_mem[s][fifo_tail[s]] = {8'(i), 24'(fifo_tail[s])};
            fifo_tail[s]++;
        end
    endtask

    task automatic apply_fifo_outputs();
        logic [1:0] s;
        for (int i = 0; i < WIDTH; i++) begin
            s = i[1:0];
            WRITE_REQ[s] = (fifo_head[s] != fifo_tail[s]);
            din_word[s]  = WRITE_REQ[s] ? fifo_mem[s][fifo_head[s]] : $urandom;
        end
    endtask

    task automatic drive_inputs();
        logic [1:0] s;
        for (int i = 0; i < WIDTH; i++) begin
            s = i[1:0];
            if (fair_mode) begin
                if (i < 2) push_word(i);
            end else if ($urandom_range(0, 99) < p_arrive) begin
                push_word(i);
            end
            if ($urandom_range(0, 99) < 10) HOLD_REQ[s] = ($urandom_range(0, 99) < p_hold);
        end
        if ($urandom_range(0, 999) < p_mask) begin
            s = 2'($urandom_range(0, 3));
            EN_MASK[s] = ~EN_MASK[s];
        end
        READY_OUT = ($urandom_range(0, 99) < p_ready);
        apply_fifo_outputs();
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 2'd0;
        m_last  = 2'(WIDTH - 1);
        m_shown = 2'd0;
        m_taken = 0;
        m_full  = 1'b0;
        m_word  = '0;
    endtask

    // Compare the DUT against the model for this cycle, then advance the model to the next edge.
    task automatic model_cycle();
        bit         do_pop;
        bit         room;
        bit         allowed;
        bit         found;
        logic [1:0] cand;
        logic [1:0] g;
        logic [3:0] exp_grant;

        g       = m_owner;
        do_pop  = 1'b0;
        if (m_busy) begin
            room    = !m_full || READY_OUT;
            allowed = (m_taken < MAX_BURST) || HOLD_REQ[g];
            do_pop  = WRITE_REQ[g] && EN_MASK[g] && allowed && room;
        end
        exp_grant = do_pop ? (4'b0001 << g) : 4'b0000;

        check_value("read_grant", 32'(READ_GRANT), 32'(exp_grant));
        check_value("write_out", 32'(WRITE_OUT), 32'(m_full));
        check_value("data_out", DATA_OUT, m_word);
        check_value("grant_id", 32'(GRANT_ID), 32'(m_shown));
        check_value("busy", 32'(BUSY), 32'(m_busy));

        if (do_pop) begin
            m_full = 1'b1;
            m_word = din_word[g];
        end else if (m_full && READY_OUT) begin
            m_full = 1'b0;
        end

        if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= WIDTH; k++) begin
                cand = m_last + 2'(k);
                if (!found && WRITE_REQ[cand] && EN_MASK[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_last  = m_owner;
                m_shown = m_owner;
                m_taken = 0;
            end
        end else begin
            if (do_pop && m_taken < MAX_BURST) m_taken++;
            if (!EN_MASK[g] || (!HOLD_REQ[g] && (m_taken >= MAX_BURST || !WRITE_REQ[g])))
                m_busy = 1'b0;
        end
    endtask

    task automatic scoreboard();
        logic [31:0] exp;
        logic [1:0]  s;
        if (WRITE_OUT && READY_OUT) begin
            if (outq.size() == 0) begin
                check_value("stream_extra", 32'(WRITE_OUT), 32'd0);
            end else begin
                exp = outq.pop_front();
                check_value("stream", DATA_OUT, exp);
                $display("XFER src=%0d seq=%0d word=%h", DATA_OUT[31:24], DATA_OUT[23:0], DATA_OUT);
            end
        end
        for (int i = 0; i < WIDTH; i++) begin
            s = i[1:0];
            if (READ_GRANT[s]) begin
                if (fifo_head[s] == fifo_tail[s]) begin
                    check_value("pop_empty", 32'(WRITE_REQ[s]), 32'd1);
                end else begin
                    outq.push_back(fifo_mem[s][fifo_head[s]]);
                    fifo_head[s]++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge BUS_CLK);
        model_cycle();
        scoreboard();
        @(posedge BUS_CLK);
        #1;
        drive_inputs();
    endtask

    task automatic run_phase(input int n, input int arrive, input int ready, input int hold,
                             input int mask, input bit fair);
        p_arrive  = arrive;
        p_ready   = ready;
        p_hold    = hold;
        p_mask    = mask;
        fair_mode = fair;
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_value({tag, "_write_out"}, 32'(WRITE_OUT), 32'd0);
        check_value({tag, "_data_out"}, DATA_OUT, 32'd0);
        check_value({tag, "_grant_id"}, 32'(GRANT_ID), 32'd0);
        check_value({tag, "_busy"}, 32'(BUSY), 32'd0);
        check_value({tag, "_read_grant"}, 32'(READ_GRANT), 32'd0);
    endtask

    // Release reset with sources 0 and 3 requesting; source 0 must win first.
    task automatic release_reset();
        @(posedge BUS_CLK);
        #1;
        EN_MASK  = 4'hF;
        HOLD_REQ = 4'h0;
        if (fifo_head[0] == fifo_tail[0]) push_word(0);
        if (fifo_head[3] == fifo_tail[3]) push_word(3);
        apply_fifo_outputs();
        BUS_RSTB = 1'b1;
        step();
        check_value("rst_prio_id", 32'(GRANT_ID), 32'd0);
        check_value("rst_prio_busy", 32'(BUSY), 32'd1);
    endtask

    task automatic reset_mid_burst();
        int budget;
        budget = 0;
        while (!(WRITE_OUT && BUSY) && budget < 500) begin
            step();
            budget++;
        end
        check_value("rst_precond", 32'(WRITE_OUT), 32'd1);
        #2;
        BUS_RSTB = 1'b0;
        #1;
        check_outputs_zero("rst_async");
        model_reset();
        outq.delete();
        @(negedge BUS_CLK);
        check_outputs_zero("rst_held");
        release_reset();
    endtask

    int remaining;

    initial begin
        BUS_RSTB  = 1'b0;
        EN_MASK   = 4'hF;
        HOLD_REQ  = 4'h0;
        READY_OUT = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            fifo_head[i] = 0;
            fifo_tail[i] = 0;
        end
        apply_fifo_outputs();
        model_reset();
        repeat (3) @(posedge BUS_CLK);
        @(negedge BUS_CLK);
        check_outputs_zero("reset");
        release_reset();

        // Two always-full sources with the burst limit active.
        HOLD_REQ = 4'h0;
        run_phase(150, 0, 100, 0, 0, 1'b1);
        run_phase(600, 30, 70, 10, 20, 1'b0);
        run_phase(300, 40, 80, 60, 5, 1'b0);
        run_phase(300, 40, 30, 20, 10, 1'b0);
        reset_mid_burst();
        run_phase(300, 35, 60, 30, 20, 1'b0);

        // Drain everything with all sources enabled and no holds.
        EN_MASK   = 4'hF;
        HOLD_REQ  = 4'h0;
        p_arrive  = 0;
        p_ready   = 100;
        p_hold    = 0;
        p_mask    = 0;
        fair_mode = 1'b0;
        remaining = 1;
        for (int c = 0; c < 3000 && remaining != 0; c++) begin
            step();
            remaining = outq.size() + int'(WRITE_OUT);
            for (int i = 0; i < WIDTH; i++) remaining += fifo_tail[i] - fifo_head[i];
        end
        check_value("drained", 32'(remaining), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
